multicycle_main_control: RTL and testbench
==========================================

// Module: multicycle_main_control
// PURPOSE
//  Main control FSM for the multicycle RV32I core. Decodes the opcode latched in the instruction register and
//  sequences fetch/decode/execute/memory/writeback. Drives datapath muxes and write enables.
//  Supplies aluOp to the ALU control unit: 00=add (address/PC), 01=sub (branch compare), 10=funct-decode.
//  Stalls on a single shared instruction/data memory via a ready handshake.
// PARAMETERS
//  none (opcodes and state encodings live in the package)
// PORTS
//  clk          in   1  rising-edge clock
//  reset        in   1  synchronous, active-high
//  op           in   7  opcode from instruction register
//  zero         in   1  ALU zero flag
//  memReady     in   1  memory has completed the current access this cycle
//  pcWrite      out  1  PC load = pcUpdate | (branch & zero)
//  adrSrc       out  1  0=PC, 1=ALUOut as memory address
//  memRead      out  1  memory read request
//  memWrite     out  1  memory write request
//  irWrite      out  1  load instruction register (and oldPC)
//  resultSrc    out  2  00=ALUOut 01=memData 10=ALUResult
//  aluSrcA      out  2  00=PC 01=oldPC 10=rs1
//  aluSrcB      out  2  00=rs2 01=immExt 10=const 4
//  aluOp        out  2  see PURPOSE
//  regWrite     out  1  register file write enable
//  illegal      out  1  sticky: unsupported opcode decoded
//  state        out  4  current state, for debug
// BEHAVIOUR
//  Reset: state<=FETCH on the clock edge with reset=1. While reset=1, pcWrite/memWrite/regWrite/irWrite forced 0
//   and illegal<=0. Reset mid-instruction abandons it with no side effects.
//  Outputs are Moore functions of state, except: irWrite/pcUpdate in FETCH and state advance out of
//   FETCH/MEMREAD/MEMWRITE are qualified by memReady. Unlisted outputs are 0.
//  FETCH: memRead, adrSrc=0, aluSrcA=00, aluSrcB=10, aluOp=00, resultSrc=10.
//   If memReady: irWrite=1, pcWrite=1, ->DECODE. Else hold, all writes 0.
//  DECODE: aluSrcA=01, aluSrcB=01, aluOp=00 (branch target precompute).
//   lw/sw(0000011/0100011)->MEMADR; R(0110011)->EXECR; I-ALU(0010011)->EXECI; beq(1100011)->BEQ;
//   jal(1101111)->JAL; other->ILLEGAL.
//  MEMADR: aluSrcA=10, aluSrcB=01, aluOp=00; lw->MEMREAD, sw->MEMWRITE.
//  MEMREAD: memRead, adrSrc=1; memReady->MEMWB else hold.
//  MEMWB: resultSrc=01, regWrite=1 ->FETCH.
//  MEMWRITE: memWrite=1, adrSrc=1, held asserted until memReady ->FETCH.
//  EXECR: aluSrcA=10, aluSrcB=00, aluOp=10 ->ALUWB. EXECI: aluSrcA=10, aluSrcB=01, aluOp=10 ->ALUWB.
//  ALUWB: resultSrc=00, regWrite=1 ->FETCH.
//  BEQ: aluSrcA=10, aluSrcB=00, aluOp=01, resultSrc=00; pcWrite=zero ->FETCH.
//  JAL: aluSrcA=01, aluSrcB=10, aluOp=00, resultSrc=00, pcWrite=1 ->ALUWB (rd<=oldPC+4).
//  ILLEGAL: all enables 0, illegal=1, terminal until reset.
//  CPI: lw 5, sw 4, R/I 4, beq 3, jal 4 at zero memory wait; each memReady=0 cycle adds one.
//  memReady ignored outside FETCH/MEMREAD/MEMWRITE.
// STRUCTURE
//  Package riscv_ctrl_pkg: typedef enum logic[3:0] state_t {FETCH,DECODE,MEMADR,MEMREAD,MEMWB,MEMWRITE,
//   EXECR,EXECI,ALUWB,BEQ,JAL,ILLEGAL}; opcode localparams OP_LW/OP_SW/OP_R/OP_I/OP_BEQ/OP_JAL;
//   aluOp constants ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10.
//  One state register plus next-state logic. Output decode is in a sub-module ctrl_output_decoder
//  (state, memReady, zero -> control vector).
// TESTING
//  1 reset=1 for 2 cycles mid-MEMWRITE -> state=FETCH, memWrite=0, illegal=0 on release.
//  2 op=0000011, memReady=1 -> states FETCH,DECODE,MEMADR,MEMREAD,MEMWB,FETCH; regWrite only in MEMWB, resultSrc=01.
//  3 op=0100011, memReady low 3 cycles in MEMWRITE -> memWrite held 4 cycles, no regWrite, 7 cycles total.
//  4 op=0110011 -> aluOp=10 in EXECR; op=1100011 with zero=1 -> pcWrite=1 in BEQ; with zero=0 -> pcWrite=0.
//  5 op=1101111 -> JAL: pcWrite=1, aluOp=00, aluSrcA=01, aluSrcB=10; then ALUWB regWrite=1.
//  6 op=1111111 -> ILLEGAL: illegal=1, no enables for 10+ cycles, memReady toggling has no effect.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared types and constants for the multicycle RV32I main control FSM.
package riscv_ctrl_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned OP_W    = 7;
    localparam int unsigned SEL_W   = 2;

    typedef enum logic [STATE_W-1:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECR,
        EXECI,
        ALUWB,
        BEQ,
        JAL,
        ILLEGAL
    } state_t;

    localparam logic [OP_W-1:0] OP_LW  = 7'b0000011;
    localparam logic [OP_W-1:0] OP_SW  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_R   = 7'b0110011;
    localparam logic [OP_W-1:0] OP_I   = 7'b0010011;
    localparam logic [OP_W-1:0] OP_BEQ = 7'b1100011;
    localparam logic [OP_W-1:0] OP_JAL = 7'b1101111;

    localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [SEL_W-1:0] RES_ALUOUT  = 2'b00;
    localparam logic [SEL_W-1:0] RES_MEMDATA = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALURES  = 2'b10;

    localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
    localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
    localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b10;

    localparam logic [SEL_W-1:0] SRCB_RS2  = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

    typedef struct packed {
        logic             pc_write;
        logic             adr_src;
        logic             mem_read;
        logic             mem_write;
        logic             ir_write;
        logic [SEL_W-1:0] result_src;
        logic [SEL_W-1:0] alu_src_a;
        logic [SEL_W-1:0] alu_src_b;
        logic [SEL_W-1:0] alu_op;
        logic             reg_write;
    } ctrl_t;

endpackage

// File: rtl/ctrl_output_decoder.sv
// Control-vector decode from FSM state; only FETCH (memReady) and BEQ (zero) look past the state.
module ctrl_output_decoder
    import riscv_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    input  logic   zero,
    output ctrl_t  ctrl_c
);

    always_comb begin
        ctrl_c = '0;
        case (state)
            FETCH: begin
                ctrl_c.mem_read   = 1'b1;
                ctrl_c.alu_src_a  = SRCA_PC;
                ctrl_c.alu_src_b  = SRCB_FOUR;
                ctrl_c.alu_op     = ALUOP_ADD;
                ctrl_c.result_src = RES_ALURES;
                ctrl_c.ir_write   = mem_ready;
                ctrl_c.pc_write   = mem_ready;
            end
            // Branch target precompute into ALUOut
            DECODE: begin
                ctrl_c.alu_src_a = SRCA_OLDPC;
                ctrl_c.alu_src_b = SRCB_IMM;
                ctrl_c.alu_op    = ALUOP_ADD;
            end
            MEMADR: begin
                ctrl_c.alu_src_a = SRCA_RS1;
                ctrl_c.alu_src_b = SRCB_IMM;
                ctrl_c.alu_op    = ALUOP_ADD;
            end
            MEMREAD: begin
                ctrl_c.mem_read = 1'b1;
                ctrl_c.adr_src  = 1'b1;
            end
            MEMWB: begin
                ctrl_c.result_src = RES_MEMDATA;
                ctrl_c.reg_write  = 1'b1;
            end
            MEMWRITE: begin
                ctrl_c.mem_write = 1'b1;
                ctrl_c.adr_src   = 1'b1;
            end
            EXECR: begin
                ctrl_c.alu_src_a = SRCA_RS1;
                ctrl_c.alu_src_b = SRCB_RS2;
                ctrl_c.alu_op    = ALUOP_FUNCT;
            end
            EXECI: begin
                ctrl_c.alu_src_a = SRCA_RS1;
                ctrl_c.alu_src_b = SRCB_IMM;
                ctrl_c.alu_op    = ALUOP_FUNCT;
            end
            ALUWB: begin
                ctrl_c.result_src = RES_ALUOUT;
                ctrl_c.reg_write  = 1'b1;
            end
            BEQ: begin
                ctrl_c.alu_src_a  = SRCA_RS1;
                ctrl_c.alu_src_b  = SRCB_RS2;
                ctrl_c.alu_op     = ALUOP_SUB;
                ctrl_c.result_src = RES_ALUOUT;
                ctrl_c.pc_write   = zero;
            end
            // PC <- branch target held in ALUOut; ALU forms oldPC+4 for the link in ALUWB
            JAL: begin
                ctrl_c.alu_src_a  = SRCA_OLDPC;
                ctrl_c.alu_src_b  = SRCB_FOUR;
                ctrl_c.alu_op     = ALUOP_ADD;
                ctrl_c.result_src = RES_ALUOUT;
                ctrl_c.pc_write   = 1'b1;
            end
            default: ctrl_c = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_main_control.sv
// Main control FSM for the multicycle RV32I core with a shared, ready-handshaked memory.
module multicycle_main_control
    import riscv_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [OP_W-1:0]    op,
    input  logic               zero,
    input  logic               memReady,
    output logic               pcWrite,
    output logic               adrSrc,
    output logic               memRead,
    output logic               memWrite,
    output logic               irWrite,
    output logic [SEL_W-1:0]   resultSrc,
    output logic [SEL_W-1:0]   aluSrcA,
    output logic [SEL_W-1:0]   aluSrcB,
    output logic [SEL_W-1:0]   aluOp,
    output logic               regWrite,
    output logic               illegal,
    output logic [STATE_W-1:0] state
);

    state_t state_q, state_d;
    logic   illegal_q, illegal_d;
    ctrl_t  ctrl_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:    if (memReady) state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECR;
                    OP_I:         state_d = EXECI;
                    OP_BEQ:       state_d = BEQ;
                    OP_JAL:       state_d = JAL;
                    default:      state_d = ILLEGAL;
                endcase
            end
            MEMADR:   state_d = (op == OP_SW) ? MEMWRITE : MEMREAD;
            MEMREAD:  if (memReady) state_d = MEMWB;
            MEMWRITE: if (memReady) state_d = FETCH;
            MEMWB:    state_d = FETCH;
            EXECR:    state_d = ALUWB;
            EXECI:    state_d = ALUWB;
            ALUWB:    state_d = FETCH;
            BEQ:      state_d = FETCH;
            JAL:      state_d = ALUWB;
            ILLEGAL:  state_d = ILLEGAL;
            default:  state_d = FETCH;
        endcase
        illegal_d = illegal_q | (state_d == ILLEGAL);
    end

    ctrl_output_decoder u_dec (
        .state     (state_q),
        .mem_ready (memReady),
        .zero      (zero),
        .ctrl_c    (ctrl_c)
    );

    // Architectural writes are suppressed while reset is held so an abandoned instruction has no effect
    assign pcWrite   = ctrl_c.pc_write  & ~reset;
    assign memWrite  = ctrl_c.mem_write & ~reset;
    assign regWrite  = ctrl_c.reg_write & ~reset;
    assign irWrite   = ctrl_c.ir_write  & ~reset;
    assign adrSrc    = ctrl_c.adr_src;
    assign memRead   = ctrl_c.mem_read;
    assign resultSrc = ctrl_c.result_src;
    assign aluSrcA   = ctrl_c.alu_src_a;
    assign aluSrcB   = ctrl_c.alu_src_b;
    assign aluOp     = ctrl_c.alu_op;
    assign illegal   = illegal_q;
    assign state     = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_main_control.sv
// Scoreboard bench for multicycle_main_control: directed per-cycle vectors, monitor on negedge.
module tb_multicycle_main_control;
    import riscv_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic       zero;
    logic       memReady;
    logic       pcWrite, adrSrc, memRead, memWrite, irWrite, regWrite, illegal;
    logic [1:0] resultSrc, aluSrcA, aluSrcB, aluOp;
    logic [3:0] state;

    multicycle_main_control dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .memReady(memReady),
        .pcWrite(pcWrite), .adrSrc(adrSrc), .memRead(memRead), .memWrite(memWrite),
        .irWrite(irWrite), .resultSrc(resultSrc), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
        .aluOp(aluOp), .regWrite(regWrite), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    // enables {pcWrite,memRead,memWrite,irWrite,regWrite,illegal}
    localparam logic [5:0] E_NONE   = 6'b000000;
    localparam logic [5:0] E_FETCH  = 6'b110100;
    localparam logic [5:0] E_FSTALL = 6'b010000;
    localparam logic [5:0] E_MRD    = 6'b010000;
    localparam logic [5:0] E_MWR    = 6'b001000;
    localparam logic [5:0] E_RW     = 6'b000010;
    localparam logic [5:0] E_PC     = 6'b100000;
    localparam logic [5:0] E_ILL    = 6'b000001;
    // muxes {adrSrc,resultSrc,aluSrcA,aluSrcB,aluOp}
    localparam logic [8:0] M_FETCH  = 9'b0_10_00_10_00;
    localparam logic [8:0] M_DECODE = 9'b0_00_01_01_00;
    localparam logic [8:0] M_MEMADR = 9'b0_00_10_01_00;
    localparam logic [8:0] M_MEMACC = 9'b1_00_00_00_00;
    localparam logic [8:0] M_MEMWB  = 9'b0_01_00_00_00;
    localparam logic [8:0] M_EXECR  = 9'b0_00_10_00_10;
    localparam logic [8:0] M_EXECI  = 9'b0_00_10_01_10;
    localparam logic [8:0] M_ZERO   = 9'b0_00_00_00_00;
    localparam logic [8:0] M_BEQ    = 9'b0_00_10_00_01;
    localparam logic [8:0] M_JAL    = 9'b0_00_01_10_00;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111, XX = 7'b1111111;

    typedef struct packed {
        logic [3:0] st;
        logic [5:0] en;
        logic [8:0] mux;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_step  = 0;

    // Apply one cycle of inputs and queue the outputs expected during that cycle
    task automatic step(input logic r, input logic [6:0] o, input logic z, input logic rdy,
                        input state_t es, input logic [5:0] ee, input logic [8:0] em);
        exp_t e;
        reset = r; op = o; zero = z; memReady = rdy;
        e.st = 4'(es); e.en = ee; e.mux = em;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t       e;
        logic [5:0] ae;
        logic [8:0] am;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                ae = {pcWrite, memRead, memWrite, irWrite, regWrite, illegal};
                am = {adrSrc, resultSrc, aluSrcA, aluSrcB, aluOp};
                n_step++;
                n_tests++;
                if (state !== e.st) begin
                    n_fail++;
                    $display("FAIL state cyc%0d: got %0d expected %0d", n_step, state, e.st);
                end
                n_tests++;
                if (ae !== e.en) begin
                    n_fail++;
                    $display("FAIL enables cyc%0d: got %b expected %b", n_step, ae, e.en);
                end
                n_tests++;
                if (am !== e.mux) begin
                    n_fail++;
                    $display("FAIL muxes cyc%0d: got %b expected %b", n_step, am, e.mux);
                end
            end
        end
    end

    initial begin : stimulus
        reset = 1'b1; op = LW; zero = 1'b0; memReady = 1'b1;
        @(posedge clk);
        #1;
        // reset state: FETCH, only memRead survives reset gating
        step(1, LW, 0, 1, FETCH, E_FSTALL, M_FETCH);

        // lw, no wait
        step(0, LW, 0, 1, FETCH,   E_FETCH, M_FETCH);
        step(0, LW, 0, 0, DECODE,  E_NONE,  M_DECODE);
        step(0, LW, 0, 0, MEMADR,  E_NONE,  M_MEMADR);
        step(0, LW, 0, 1, MEMREAD, E_MRD,   M_MEMACC);
        step(0, LW, 0, 1, MEMWB,   E_RW,    M_MEMWB);

        // sw with a fetch stall and three write-wait cycles
        step(0, SW, 0, 0, FETCH,    E_FSTALL, M_FETCH);
        step(0, SW, 0, 1, FETCH,    E_FETCH,  M_FETCH);
        step(0, SW, 0, 1, DECODE,   E_NONE,   M_DECODE);
        step(0, SW, 0, 1, MEMADR,   E_NONE,   M_MEMADR);
        step(0, SW, 0, 0, MEMWRITE, E_MWR,    M_MEMACC);
        step(0, SW, 0, 0, MEMWRITE, E_MWR,    M_MEMACC);
        step(0, SW, 0, 0, MEMWRITE, E_MWR,    M_MEMACC);
        step(0, SW, 0, 1, MEMWRITE, E_MWR,    M_MEMACC);

        // R-type then I-type
        step(0, RT, 0, 1, FETCH,  E_FETCH, M_FETCH);
        step(0, RT, 0, 0, DECODE, E_NONE,  M_DECODE);
        step(0, RT, 0, 0, EXECR,  E_NONE,  M_EXECR);
        step(0, RT, 0, 0, ALUWB,  E_RW,    M_ZERO);
        step(0, IT, 0, 1, FETCH,  E_FETCH, M_FETCH);
        step(0, IT, 0, 1, DECODE, E_NONE,  M_DECODE);
        step(0, IT, 0, 1, EXECI,  E_NONE,  M_EXECI);
        step(0, IT, 0, 1, ALUWB,  E_RW,    M_ZERO);

        // beq taken then not taken
        step(0, BQ, 1, 1, FETCH,  E_FETCH, M_FETCH);
        step(0, BQ, 1, 1, DECODE, E_NONE,  M_DECODE);
        step(0, BQ, 1, 1, BEQ,    E_PC,    M_BEQ);
        step(0, BQ, 0, 1, FETCH,  E_FETCH, M_FETCH);
        step(0, BQ, 0, 1, DECODE, E_NONE,  M_DECODE);
        step(0, BQ, 0, 1, BEQ,    E_NONE,  M_BEQ);

        // jal
        step(0, JL, 0, 1, FETCH,  E_FETCH, M_FETCH);
        step(0, JL, 0, 1, DECODE, E_NONE,  M_DECODE);
        step(0, JL, 0, 0, JAL,    E_PC,    M_JAL);
        step(0, JL, 0, 0, ALUWB,  E_RW,    M_ZERO);

        // reset for two cycles mid-MEMWRITE
        step(0, SW, 0, 1, FETCH,    E_FETCH,  M_FETCH);
        step(0, SW, 0, 1, DECODE,   E_NONE,   M_DECODE);
        step(0, SW, 0, 1, MEMADR,   E_NONE,   M_MEMADR);
        step(0, SW, 0, 0, MEMWRITE, E_MWR,    M_MEMACC);
        step(1, SW, 0, 0, MEMWRITE, E_NONE,   M_MEMACC);
        step(1, SW, 0, 0, FETCH,    E_FSTALL, M_FETCH);
        step(0, SW, 0, 0, FETCH,    E_FSTALL, M_FETCH);

        // illegal opcode: terminal, memReady toggling ignored
        step(0, XX, 0, 1, FETCH,  E_FETCH, M_FETCH);
        step(0, XX, 0, 1, DECODE, E_NONE,  M_DECODE);
        for (int i = 0; i < 11; i++)
            step(0, (i % 2 == 0) ? XX : LW, 1'(i % 3 == 0), 1'(i % 2), ILLEGAL, E_ILL, M_ZERO);
        // reset clears the sticky flag on the edge
        step(1, LW, 0, 1, ILLEGAL, E_ILL,   M_ZERO);
        step(0, LW, 0, 1, FETCH,   E_FETCH, M_FETCH);
        step(0, LW, 0, 1, DECODE,  E_NONE,  M_DECODE);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
